// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side handshake and redirect bus for the PC generator.
// master: the PC generator (drives pc, pc_valid, redirect_taken, fault).
// slave:  the fetch/control side (drives ready, halt and redirect requests).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              pc_ready;
    logic              halt;
    logic              exc_valid;
    logic [ADDR_W-1:0] exc_addr;
    logic              br_valid;
    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              redirect_taken;
    logic              fault;

    modport master (
        input  pc_ready, halt, exc_valid, exc_addr, br_valid, br_addr,
        output pc, pc_valid, redirect_taken, fault
    );

    modport slave (
        output pc_ready, halt, exc_valid, exc_addr, br_valid, br_addr,
        input  pc, pc_valid, redirect_taken, fault
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with exception/branch redirects and halt.
// Optional macro PC_GEN_ALIGN_CHECK_EN: misaligned branch targets trap into
// a sticky FAULT state instead of being silently masked.
//
// state | meaning
// BOOT  | first cycle after reset; pc = RESET_VEC, not yet valid
// RUN   | issuing PCs; advances on handshake, takes redirects
// HALT  | stopped, pc_valid low; only an exception restarts
// FAULT | (macro only) misaligned branch seen; only an exception restarts
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter int                STEP       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                ALIGN_BITS = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
`ifdef PC_GEN_ALIGN_CHECK_EN
        ,
        FAULT
`endif
    } state_t;

    // Low bits that must be zero in a fetch address; all-zero when ALIGN_BITS=0.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              redir_q, redir_d;
    logic [ADDR_W-1:0] exc_target;
    logic [ADDR_W-1:0] br_target;

    assign exc_target = bus.exc_addr & ~LOW_MASK;
    assign br_target  = bus.br_addr & ~LOW_MASK;

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic br_misaligned;

    assign br_misaligned = |(bus.br_addr & LOW_MASK);
`endif

    // Next-state and next-output decode; redirect_taken defaults low so it pulses.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        redir_d = 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (bus.exc_valid) begin
                    pc_d    = exc_target;
                    valid_d = 1'b1;
                    redir_d = 1'b1;
                end else if (bus.halt) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (bus.br_valid) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
                    if (br_misaligned) begin
                        state_d = FAULT;
                        pc_d    = bus.br_addr;
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                        redir_d = 1'b1;
                    end else begin
                        pc_d    = br_target;
                        valid_d = 1'b1;
                        redir_d = 1'b1;
                    end
`else
                    pc_d    = br_target;
                    valid_d = 1'b1;
                    redir_d = 1'b1;
`endif
                end else if (bus.pc_ready) begin
                    pc_d = pc_q + STEP_W;
                end
            end
            HALT: begin
                if (bus.exc_valid) begin
                    state_d = RUN;
                    pc_d    = exc_target;
                    valid_d = 1'b1;
                    redir_d = 1'b1;
                end
            end
`ifdef PC_GEN_ALIGN_CHECK_EN
            FAULT: begin
                if (bus.exc_valid) begin
                    state_d = RUN;
                    pc_d    = exc_target;
                    valid_d = 1'b1;
                    redir_d = 1'b1;
                    fault_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VEC;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            redir_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
`ifdef PC_GEN_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_valid       = valid_q;
    assign bus.redirect_taken = redir_q;
`ifdef PC_GEN_ALIGN_CHECK_EN
    assign bus.fault          = fault_q;
`else
    assign bus.fault          = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen (default parameters)
// against a behavioural model; honours PC_GEN_ALIGN_CHECK_EN if defined.
module tb_pc_gen;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;
`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic clk;
    logic rst;

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode  = M_BOOT;
    logic [31:0] m_pc    = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_redir = 1'b0;
    bit          m_fault = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural rule set: what one rising edge does given the inputs.
    task automatic model_edge(input bit r, input bit rdy, input bit h, input bit e,
                              input logic [31:0] ea, input bit b, input logic [31:0] ba);
        m_redir = 1'b0;
        if (r) begin
            m_mode = M_BOOT; m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN; m_valid = 1'b1;
        end else if (e) begin
            m_mode = M_RUN; m_pc = {ea[31:2], 2'b00}; m_valid = 1'b1;
            m_redir = 1'b1; m_fault = 1'b0;
        end else if (m_mode == M_RUN) begin
            if (h) begin
                m_mode = M_HALT; m_valid = 1'b0;
            end else if (b) begin
                m_redir = 1'b1;
                if (ALIGN_CHECK && ba[1:0] != 2'b00) begin
                    m_mode = M_FAULT; m_pc = ba; m_valid = 1'b0; m_fault = 1'b1;
                end else begin
                    m_pc = {ba[31:2], 2'b00};
                end
            end else if (rdy) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle: drive at negedge, model the edge, compare at the next negedge.
    task automatic step(input bit r, input bit rdy, input bit h, input bit e,
                        input logic [31:0] ea, input bit b, input logic [31:0] ba);
        rst = r;
        bus.pc_ready = rdy; bus.halt = h;
        bus.exc_valid = e; bus.exc_addr = ea;
        bus.br_valid = b; bus.br_addr = ba;
        @(posedge clk);
        model_edge(r, rdy, h, e, ea, b, ba);
        @(negedge clk);
        check("pc", bus.pc, m_pc);
        check("pc_valid", {31'b0, bus.pc_valid}, {31'b0, m_valid});
        check("redirect_taken", {31'b0, bus.redirect_taken}, {31'b0, m_redir});
        check("fault", {31'b0, bus.fault}, {31'b0, m_fault});
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, rdy, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          r, rdy, h, e, b;
        logic [31:0] ea, ba;

        rst = 1'b1;
        bus.pc_ready = 1'b0; bus.halt = 1'b0;
        bus.exc_valid = 1'b0; bus.exc_addr = '0;
        bus.br_valid = 1'b0; bus.br_addr = '0;
        @(negedge clk);

        // Reset held two edges, then release with pc_ready high.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        check("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
        idle(1'b1);
        check("boot_pc", bus.pc, 32'h0);
        check("boot_valid", {31'b0, bus.pc_valid}, 32'h1);
        idle(1'b1);
        check("seq_pc4", bus.pc, 32'h4);
        idle(1'b1);
        check("seq_pc8", bus.pc, 32'h8);

        // Stall at 0x100.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        check("br_pc100", bus.pc, 32'h100);
        check("br_pulse", {31'b0, bus.redirect_taken}, 32'h1);
        idle(1'b0); idle(1'b0); idle(1'b0);
        check("stall_pc", bus.pc, 32'h100);
        check("stall_valid", {31'b0, bus.pc_valid}, 32'h1);
        idle(1'b1);
        check("stall_release", bus.pc, 32'h104);

        // Exception wins over halt and branch together.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C00_0000, 1'b1, 32'h200);
        check("exc_pc", bus.pc, 32'h1C00_0000);
        check("exc_pulse", {31'b0, bus.redirect_taken}, 32'h1);
        idle(1'b0);
        check("exc_pulse_end", {31'b0, bus.redirect_taken}, 32'h0);
        check("exc_run_valid", {31'b0, bus.pc_valid}, 32'h1);

        // Halt drops a simultaneous branch; only an exception leaves HALT.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
        check("halt_valid", {31'b0, bus.pc_valid}, 32'h0);
        check("halt_pc", bus.pc, 32'h1C00_0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
        check("halt_ignore_br", bus.pc, 32'h1C00_0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        check("halt_exit_pc", bus.pc, 32'h8);
        check("halt_exit_valid", {31'b0, bus.pc_valid}, 32'h1);

        // Exception target masking and wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
        check("exc_mask", bus.pc, 32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle(1'b1);
        check("wrap_pc", bus.pc, 32'h0);
        check("wrap_no_fault", {31'b0, bus.fault}, 32'h0);

        // Misaligned branch target.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
`ifdef PC_GEN_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, bus.fault}, 32'h1);
        check("mis_pc", bus.pc, 32'h102);
        check("mis_valid", {31'b0, bus.pc_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
        check("fault_sticky", {31'b0, bus.fault}, 32'h1);
`else
        check("mis_pc", bus.pc, 32'h100);
        check("mis_fault", {31'b0, bus.fault}, 32'h0);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("fault_clear", {31'b0, bus.fault}, 32'h0);
        check("fault_exit_pc", bus.pc, 32'h40);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 15) == 0);
            e   = ($urandom_range(0, 15) == 0);
            b   = ($urandom_range(0, 7) == 0);
            ea  = $urandom;
            ba  = $urandom;
            if ($urandom_range(0, 1) == 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFF0 | {28'h0, ba[3:0]};
            step(r, rdy, h, e, ea, b, ba);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, 32, PC width in bits.
REQ-002 Parameter STEP, 4, sequential increment added per accepted PC.
REQ-003 Parameter RESET_VEC, 0, PC value loaded by reset, ADDR_W wide.
REQ-004 Parameter ALIGN_BITS, 2, number of low PC bits that must be zero; 0 disables alignment handling.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 pc_ready  input  1  fetch stage accepts current pc this cycle.
REQ-008 halt  input  1  request to stop issuing PCs.
REQ-009 exc_valid  input  1  exception/ERTN redirect request.
REQ-010 exc_addr  input  ADDR_W  exception redirect target.
REQ-011 br_valid  input  1  branch/jump redirect request.
REQ-012 br_addr  input  ADDR_W  branch redirect target.
REQ-013 pc  output  ADDR_W  current fetch PC, registered.
REQ-014 pc_valid  output  1  pc is valid for fetch, registered.
REQ-015 redirect_taken  output  1  one-cycle pulse: a redirect was applied at the previous edge.
REQ-016 fault  output  1  sticky misaligned-branch flag, present only with PC_GEN_ALIGN_CHECK_EN; without the macro, tied to 0.

Function
REQ-017 FSM states: BOOT, RUN, HALT, plus FAULT when PC_GEN_ALIGN_CHECK_EN is defined.
REQ-018 BOOT: at the first edge with rst=0, go to RUN, pc_valid<=1, pc stays RESET_VEC; inputs are ignored in BOOT.
REQ-019 Priority at each edge in RUN: exc_valid > halt > br_valid > sequential advance > hold.
REQ-020 RUN, exc_valid=1: pc<=exc_addr (low ALIGN_BITS masked to 0), pc_valid<=1, redirect_taken<=1, independent of pc_ready.
REQ-021 RUN, halt=1 and no exc_valid: go to HALT, pc_valid<=0, pc held; a simultaneous br_valid is dropped.
REQ-022 RUN, br_valid=1 and neither of the above: pc<=br_addr (masked), pc_valid<=1, redirect_taken<=1, independent of pc_ready.
REQ-023 RUN, no redirect/halt, pc_ready=1: pc<=pc+STEP modulo 2^ADDR_W; wrap from all-ones region to low addresses with no flag.
REQ-024 RUN, no redirect/halt, pc_ready=0: pc and pc_valid hold unchanged.
REQ-025 HALT: exc_valid=1 applies REQ-020 and returns to RUN; br_valid and pc_ready are ignored; halt level is not needed to stay in HALT.
REQ-026 redirect_taken is 0 on every edge that does not apply a redirect; it is never high for two cycles from one request.
REQ-027 pc changes only on a handshake (pc_valid & pc_ready), a redirect or reset.

Reset
REQ-028 rst=1 at an edge, in any state and regardless of other inputs: state<=BOOT, pc<=RESET_VEC, pc_valid<=0, redirect_taken<=0, fault<=0.
REQ-029 rst held over several edges keeps all outputs at reset values; BOOT lasts exactly one edge after release.

Configuration
REQ-030 Macro PC_GEN_ALIGN_CHECK_EN, undefined: branch targets are masked like exception targets; FAULT state does not exist; fault=0.
REQ-031 PC_GEN_ALIGN_CHECK_EN, defined: a br_valid applied per REQ-022 with any nonzero low ALIGN_BITS goes to FAULT, pc<=br_addr unmasked, pc_valid<=0, fault<=1, redirect_taken<=1.
REQ-032 FAULT: fault stays 1; only exc_valid (REQ-020, returns to RUN, clears fault) or rst exits; halt, br_valid and pc_ready are ignored.
REQ-033 ALIGN_BITS=0 with the macro defined: FAULT is unreachable.

Verification
REQ-034 Defaults, rst=1 for 2 edges then 0, pc_ready=1 -> pc_valid 0 during reset, 1 at first release edge with pc=0x0, then 0x4, 0x8.
REQ-035 pc=0x100, pc_ready=0 for 3 cycles -> pc stays 0x100, pc_valid=1; pc_ready=1 -> 0x104.
REQ-036 Same cycle exc_valid=1 exc_addr=0x1C00_0000, br_valid=1 br_addr=0x200, halt=1 -> pc=0x1C00_0000, redirect_taken pulses one cycle, state RUN.
REQ-037 halt=1 with br_valid=1 -> HALT, pc_valid=0, br dropped; later exc_addr=0x8 -> pc=0x8, pc_valid=1.
REQ-038 pc=0xFFFF_FFFC, pc_ready=1 -> pc=0x0000_0000, no flag.
REQ-039 Macro on, br_addr=0x102 -> fault=1, pc=0x102, pc_valid=0; exc_addr=0x40 -> fault=0, pc=0x40; macro off, same stimulus -> pc=0x100, fault=0.
